// File: rtl/gf180_ram_pkg.sv
// Shared constants, FSM state type and geometry helpers for the gf180 SRAM Wishbone bank.
package gf180_ram_pkg;

  localparam int unsigned MACRO_DEPTH = 512;
  localparam int unsigned MACRO_W     = 8;
  localparam int unsigned MACRO_AW    = 9;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    ACK
  } state_t;

  // Number of byte-offset address bits dropped to form the word address.
  function automatic int unsigned off_bits(input int unsigned data_w);
    return $clog2(data_w / MACRO_W);
  endfunction

  // Row index width; zero when the bank is a single row.
  function automatic int unsigned row_bits(input int unsigned depth);
    return $clog2(depth / MACRO_DEPTH);
  endfunction

endpackage

// File: rtl/gf180_ram_512x8_wrapper.sv
// Behavioural model of the 512x8 gf180 SRAM macro wrapper: active-low CEN/GWEN/WEN,
// Q updated on an enabled read edge and held until the next enabled access.
module gf180_ram_512x8_wrapper (
`ifdef USE_POWER_PINS
  inout  wire        VDD,
  inout  wire        VSS,
`endif
  input  logic       CLK,
  input  logic       CEN,
  input  logic       GWEN,
  input  logic [7:0] WEN,
  input  logic [8:0] A,
  input  logic [7:0] D,
  output logic [7:0] Q
);

  logic [7:0] mem [512];

  always_ff @(posedge CLK) begin
    if (!CEN) begin
      if (!GWEN) begin
        for (int unsigned b = 0; b < 8; b++) begin
          if (!WEN[b]) mem[A][b] <= D[b];
        end
      end else begin
        Q <= mem[A];
      end
    end
  end

endmodule

// File: rtl/gf180_ram_row.sv
// One row of the bank: N_COLS byte-wide macros sharing address, enable and write strobe.
module gf180_ram_row
  import gf180_ram_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
`ifdef USE_POWER_PINS
  inout  wire                         VDD,
  inout  wire                         VSS,
`endif
  input  logic                        clk,
  input  logic                        en,
  input  logic                        we,
  input  logic [DATA_W/MACRO_W-1:0]   mask,
  input  logic [MACRO_AW-1:0]         addr,
  input  logic [DATA_W-1:0]           wdata,
  output logic [DATA_W-1:0]           rdata
);

  localparam int unsigned N_COLS = DATA_W / MACRO_W;

  // Idle rows present CEN=1, GWEN=1, WEN=FF regardless of the shared bus signals.
  for (genvar c = 0; c < N_COLS; c++) begin : g_col
    gf180_ram_512x8_wrapper u_macro (
`ifdef USE_POWER_PINS
      .VDD  (VDD),
      .VSS  (VSS),
`endif
      .CLK  (clk),
      .CEN  (~en),
      .GWEN (~(en & we)),
      .WEN  ((en && we && mask[c]) ? 8'h00 : 8'hFF),
      .A    (addr),
      .D    (wdata[c*MACRO_W +: MACRO_W]),
      .Q    (rdata[c*MACRO_W +: MACRO_W])
    );
  end

endmodule

// File: rtl/gf180_ram_wb_bank.sv
// Wishbone-slave RAM bank of DEPTH/512 rows by DATA_W/8 columns of gf180 512x8 macros,
// with byte-lane writes, a registered read path and an error response out of range.
module gf180_ram_wb_bank
  import gf180_ram_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADR_W  = 32
) (
`ifdef USE_POWER_PINS
  inout  wire                       VDD,
  inout  wire                       VSS,
`endif
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic                      wbs_cyc_i,
  input  logic                      wbs_stb_i,
  input  logic                      wbs_we_i,
  input  logic [DATA_W/8-1:0]       wbs_sel_i,
  input  logic [ADR_W-1:0]          wbs_adr_i,
  input  logic [DATA_W-1:0]         wbs_dat_i,
  output logic [DATA_W-1:0]         wbs_dat_o,
  output logic                      wbs_ack_o,
  output logic                      wbs_err_o
);

  localparam int unsigned N_ROWS = DEPTH / MACRO_DEPTH;
  localparam int unsigned OFF    = off_bits(DATA_W);
  localparam int unsigned ROW_W  = row_bits(DEPTH);
  localparam int unsigned ROW_SW = (ROW_W == 0) ? 1 : ROW_W;

  state_t              state, state_next;
  logic [ADR_W-1:0]    word;
  logic                in_range;
  logic [MACRO_AW-1:0] maddr;
  logic [ROW_SW-1:0]   row_sel, row_q;
  logic [N_ROWS-1:0]   row_dec, row_en;
  logic                wr, capture, latch_row, ack_next, err_next;
  logic [DATA_W-1:0]   row_rdata [N_ROWS];
  logic [DATA_W-1:0]   rd_word;

  assign word     = wbs_adr_i >> OFF;
  assign in_range = (word < ADR_W'(DEPTH));
  assign maddr    = word[MACRO_AW-1:0];

  if (N_ROWS == 1) begin : g_one_row
    assign row_sel = '0;
  end else begin : g_multi_row
    assign row_sel = word[MACRO_AW +: ROW_W];
  end

  always_comb begin
    row_dec = '0;
    for (int unsigned r = 0; r < N_ROWS; r++) begin
      if (row_sel == ROW_SW'(r)) row_dec[r] = 1'b1;
    end
  end

  always_comb begin
    rd_word = '0;
    for (int unsigned r = 0; r < N_ROWS; r++) begin
      if (row_q == ROW_SW'(r)) rd_word = row_rdata[r];
    end
  end

  always_comb begin
    state_next = state;
    row_en     = '0;
    wr         = 1'b0;
    capture    = 1'b0;
    latch_row  = 1'b0;
    ack_next   = 1'b0;
    err_next   = 1'b0;
    case (state)
      IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          if (!in_range) begin
            err_next   = 1'b1;
            state_next = ACK;
          end else if (wbs_we_i) begin
            wr         = 1'b1;
            if (|wbs_sel_i) row_en = row_dec;
            ack_next   = 1'b1;
            state_next = ACK;
          end else begin
            row_en     = row_dec;
            latch_row  = 1'b1;
            state_next = RD;
          end
        end
      end
      RD: begin
        if (!wbs_cyc_i) begin
          state_next = IDLE;
        end else begin
          capture    = 1'b1;
          ack_next   = 1'b1;
          state_next = ACK;
        end
      end
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // Macro enables are combinational, so reset must mask them in the same cycle.
    if (wb_rst_i) row_en = '0;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      wbs_ack_o <= 1'b0;
      wbs_err_o <= 1'b0;
      wbs_dat_o <= '0;
      row_q     <= '0;
    end else begin
      state     <= state_next;
      wbs_ack_o <= ack_next;
      wbs_err_o <= err_next;
      if (latch_row) row_q <= row_sel;
      if (capture) wbs_dat_o <= rd_word;
    end
  end

  for (genvar r = 0; r < N_ROWS; r++) begin : g_row
    gf180_ram_row #(
      .DATA_W (DATA_W)
    ) u_row (
`ifdef USE_POWER_PINS
      .VDD   (VDD),
      .VSS   (VSS),
`endif
      .clk   (wb_clk_i),
      .en    (row_en[r]),
      .we    (wr),
      .mask  (wbs_sel_i),
      .addr  (maddr),
      .wdata (wbs_dat_i),
      .rdata (row_rdata[r])
    );
  end

endmodule

// File: tb/tb_gf180_ram_wb_bank.sv
// Self-checking bench for gf180_ram_wb_bank (DATA_W=32, DEPTH=1024): directed vector table,
// multi-cycle corner sequences and randomized traffic against a word-array memory model.
module tb_gf180_ram_wb_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat_i;
  logic [31:0] dat_o;
  logic        ack, err;

  int checks   = 0;
  int failures = 0;
  logic [31:0] last_rd;

  always #5 clk = ~clk;

  gf180_ram_wb_bank #(
    .DATA_W (32),
    .DEPTH  (1024),
    .ADR_W  (32)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbs_cyc_i (cyc),
    .wbs_stb_i (stb),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (dat_i),
    .wbs_dat_o (dat_o),
    .wbs_ack_o (ack),
    .wbs_err_o (err)
  );

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        exp_err;
    int          exp_lat;
    int          exp_cen;
    logic [31:0] exp_rd;
  } vec_t;

  function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] s, input logic e, input int l, input int c,
                              input logic [31:0] r);
    vec_t v;
    v.we = w; v.adr = a; v.dat = d; v.sel = s;
    v.exp_err = e; v.exp_lat = l; v.exp_cen = c; v.exp_rd = r;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One Wishbone transfer; counts cycles with any macro row enabled, including the ack cycle.
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic a_seen, output logic e_seen,
                      output int lat, output int cen, output logic [31:0] rd);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d; sel = s;
    lat = 0; cen = 0; a_seen = 1'b0; e_seen = 1'b0;
    while (!(a_seen || e_seen) && lat < 8) begin
      #1;
      if (|dut.row_en) cen++;
      @(posedge clk); #1;
      lat++;
      a_seen = ack;
      e_seen = err;
    end
    rd = dat_o;
    #1;
    if (|dut.row_en) cen++;
    cyc = 1'b0; stb = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    logic a, e;
    int lat, cen;
    logic [31:0] rd;
    xfer(v.we, v.adr, v.dat, v.sel, a, e, lat, cen, rd);
    chk({tag, "_ack"}, a, !v.exp_err);
    chk({tag, "_err"}, e, v.exp_err);
    chk({tag, "_lat"}, lat, v.exp_lat);
    chk({tag, "_cen"}, cen, v.exp_cen);
    if (!v.we && !v.exp_err) begin
      chk({tag, "_rdata"}, rd, v.exp_rd);
      last_rd = v.exp_rd;
    end else begin
      chk({tag, "_hold"}, rd, last_rd);
    end
  endtask

  logic [31:0] mdl [1024];
  int unsigned pool [8] = '{3, 100, 300, 510, 520, 700, 900, 1022};

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [15];
    logic [31:0] bb_adr [4] = '{32'h010, 32'h014, 32'h818, 32'h81C};
    logic [31:0] bb_dat [4] = '{32'h0101_0101, 32'h0202_0202, 32'h0303_0303, 32'h0404_0404};
    int n_ack, n_cen, idx;

    tbl[0]  = mk(1, 32'h000, 32'hDEADBEEF, 4'hF, 0, 1, 1, 32'h0);
    tbl[1]  = mk(0, 32'h000, 32'h0,        4'hF, 0, 2, 1, 32'hDEADBEEF);
    tbl[2]  = mk(1, 32'h004, 32'h55555555, 4'hF, 0, 1, 1, 32'h0);
    tbl[3]  = mk(1, 32'h804, 32'hAAAAAAAA, 4'hF, 0, 1, 1, 32'h0);
    tbl[4]  = mk(1, 32'h804, 32'h11223344, 4'h5, 0, 1, 1, 32'h0);
    tbl[5]  = mk(0, 32'h804, 32'h0,        4'h0, 0, 2, 1, 32'hAA22AA44);
    tbl[6]  = mk(0, 32'h004, 32'h0,        4'h3, 0, 2, 1, 32'h55555555);
    tbl[7]  = mk(1, 32'h004, 32'hFFFFFFFF, 4'h0, 0, 1, 0, 32'h0);
    tbl[8]  = mk(0, 32'h1000, 32'h0,       4'hF, 1, 1, 0, 32'h0);
    tbl[9]  = mk(1, 32'h1000, 32'h12345678, 4'hF, 1, 1, 0, 32'h0);
    tbl[10] = mk(0, 32'h006, 32'h0,        4'hF, 0, 2, 1, 32'h55555555);
    tbl[11] = mk(1, 32'h7FC, 32'hCAFEF00D, 4'hF, 0, 1, 1, 32'h0);
    tbl[12] = mk(1, 32'hFFC, 32'h0BADC0DE, 4'hF, 0, 1, 1, 32'h0);
    tbl[13] = mk(0, 32'h7FF, 32'h0,        4'hF, 0, 2, 1, 32'hCAFEF00D);
    tbl[14] = mk(0, 32'hFFD, 32'h0,        4'hF, 0, 2, 1, 32'h0BADC0DE);

    // Reset with a read request pending: no macro may be enabled while reset is high.
    rst = 1'b1; cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = '0; dat_i = '0;
    @(posedge clk); #1;
    chk("rst_cen_c0", {31'b0, |dut.row_en}, 32'h0);
    @(posedge clk); #1;
    chk("rst_cen_c1", {31'b0, |dut.row_en}, 32'h0);
    chk("rst_ack", ack, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_dat", dat_o, 32'h0);
    rst = 1'b0; cyc = 1'b0; stb = 1'b0;
    last_rd = '0;

    for (int i = 0; i < 15; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Abort: drop cyc while in RD.
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h804; sel = 4'hF;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    n_ack = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (ack || err) n_ack++;
    end
    chk("abort_no_ack", n_ack, 0);
    chk("abort_dat_hold", dat_o, last_rd);
    run_vec(mk(0, 32'h000, 32'h0, 4'hF, 0, 2, 1, 32'hDEADBEEF), "post_abort");

    // Reset while in RD.
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h804; sel = 4'hF;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rstrd_cen", {31'b0, |dut.row_en}, 32'h0);
    @(posedge clk); #1;
    chk("rstrd_ack", ack, 1'b0);
    chk("rstrd_dat", dat_o, 32'h0);
    rst = 1'b0; cyc = 1'b0; stb = 1'b0;
    last_rd = '0;
    @(posedge clk); #1;
    chk("rstrd_ack_after", ack, 1'b0);
    run_vec(mk(0, 32'h804, 32'h0, 4'hF, 0, 2, 1, 32'hAA22AA44), "post_rst");

    // Back-to-back writes with cyc/stb held high across the ack cycles.
    @(posedge clk); #1;
    idx = 0; n_ack = 0; n_cen = 0;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = bb_adr[0]; dat_i = bb_dat[0];
    repeat (10) begin
      #1;
      if (|dut.row_en) n_cen++;
      @(posedge clk); #1;
      if (ack) begin
        n_ack++;
        idx++;
        if (idx < 4) begin
          adr = bb_adr[idx]; dat_i = bb_dat[idx];
        end else begin
          cyc = 1'b0; stb = 1'b0;
        end
      end
    end
    cyc = 1'b0; stb = 1'b0;
    chk("b2b_acks", n_ack, 4);
    chk("b2b_cen_pulses", n_cen, 4);
    for (int i = 0; i < 4; i++)
      run_vec(mk(0, bb_adr[i], 32'h0, 4'hF, 0, 2, 1, bb_dat[i]), $sformatf("b2b_rd%0d", i));

    // Randomized traffic against a word-array model.
    for (int i = 0; i < 8; i++) begin
      logic [31:0] d;
      d = $urandom;
      mdl[pool[i]] = d;
      run_vec(mk(1, pool[i] * 4, d, 4'hF, 0, 1, 1, 32'h0), $sformatf("pre%0d", i));
    end
    for (int i = 0; i < 80; i++) begin
      logic        w;
      logic [3:0]  s;
      logic [31:0] d, a;
      int unsigned wd;
      w  = 1'($urandom_range(0, 1));
      s  = 4'($urandom_range(0, 15));
      d  = $urandom;
      if ($urandom_range(0, 9) == 0) begin
        a = $urandom_range(32'h1000, 32'hFFFF_FFFF);
        run_vec(mk(w, a, d, s, 1, 1, 0, 32'h0), $sformatf("rnd%0d_oor", i));
      end else begin
        wd = pool[$urandom_range(0, 7)];
        a  = wd * 4 + $urandom_range(0, 3);
        if (w) begin
          for (int b = 0; b < 4; b++)
            if (s[b]) mdl[wd][8*b +: 8] = d[8*b +: 8];
          run_vec(mk(1, a, d, s, 0, 1, (s != 0) ? 1 : 0, 32'h0), $sformatf("rnd%0d_wr", i));
        end else begin
          run_vec(mk(0, a, d, s, 0, 2, 1, mdl[wd]), $sformatf("rnd%0d_rd", i));
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
